// File: rtl/matrix_op_sequencer_if.sv
// Signal bundle between matrix_op_sequencer and the parts of matrix_calc_top around it.
// master drives the inputs: debounced button, DIP select and the calc engine status. slave is the sequencer.
interface matrix_op_sequencer_if #(
    parameter int OP_W  = 4,
    parameter int CNT_W = 4
) ();
    logic             button;
    logic [OP_W-1:0]  mode_sel;
    logic             calc_done;
    logic             error_in;
    logic [3:0]       state;
    logic             start_calc;
    logic [OP_W-1:0]  op_type;
    logic             error_led;
    logic [1:0]       err_code;
    logic             start_countdown;
    logic [CNT_W-1:0] countdown_val;

    modport master (
        output button, mode_sel, calc_done, error_in,
        input  state, start_calc, op_type, error_led, err_code, start_countdown, countdown_val
    );

    modport slave (
        input  button, mode_sel, calc_done, error_in,
        output state, start_calc, op_type, error_led, err_code, start_countdown, countdown_val
    );
endinterface

// File: rtl/matrix_op_sequencer.sv
// Matrix-calculator control FSM covering op select, calc start/complete, and error recovery with a seconds countdown.
// Defining MATRIX_CALC_WDOG_EN adds a CALC watchdog that reports err_code 3.
module matrix_op_sequencer #(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int OP_W         = 4,
    parameter int NUM_OPS      = 5,
    parameter int COUNTDOWN_S  = 10,
    parameter int CALC_TIMEOUT = 1_000_000
) (
    input  logic                clk,
    input  logic                rst_n,
    matrix_op_sequencer_if.slave bus
);
    localparam int CNT_W  = $clog2(COUNTDOWN_S + 1);
    localparam int TICK_W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_FREQ - 1);
    localparam logic [OP_W:0]     NUM_OPS_L = (OP_W + 1)'(NUM_OPS);

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        MENU  = 4'd1,
        CALC  = 4'd2,
        DONE  = 4'd3,
        ERROR = 4'd4
    } state_e;

    state_e            state_q, state_d;
    logic              button_q, button_d;
    logic              btn_rise_q, btn_rise_d;
    logic              start_calc_q, start_calc_d;
    logic              start_cd_q, start_cd_d;
    logic              error_led_q, error_led_d;
    logic [OP_W-1:0]   op_type_q, op_type_d;
    logic [1:0]        err_code_q, err_code_d;
    logic [CNT_W-1:0]  countdown_q, countdown_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic              op_valid;

`ifdef MATRIX_CALC_WDOG_EN
    localparam int WD_W = (CALC_TIMEOUT > 1) ? $clog2(CALC_TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(CALC_TIMEOUT - 1);
    logic [WD_W-1:0] wdog_q, wdog_d;
`endif

    assign op_valid = {1'b0, bus.mode_sel} < NUM_OPS_L;

    always_comb begin
        state_d      = state_q;
        button_d     = bus.button;
        btn_rise_d   = bus.button & ~button_q;
        start_calc_d = 1'b0;
        start_cd_d   = 1'b0;
        op_type_d    = op_type_q;
        err_code_d   = err_code_q;
        countdown_d  = countdown_q;
        tick_d       = '0;
`ifdef MATRIX_CALC_WDOG_EN
        wdog_d       = '0;
`endif
        case (state_q)
            IDLE: if (btn_rise_q) state_d = MENU;
            MENU: begin
                if (btn_rise_q && op_valid) begin
                    state_d      = CALC;
                    op_type_d    = bus.mode_sel;
                    start_calc_d = 1'b1;
                    err_code_d   = 2'd0;
                end else if (btn_rise_q) begin
                    state_d    = ERROR;
                    err_code_d = 2'd1;
                end
            end
            CALC: begin
                // error_in outranks calc_done, and calc_done outranks the watchdog
                if (bus.error_in) begin
                    state_d    = ERROR;
                    err_code_d = 2'd2;
                end else if (bus.calc_done) begin
                    state_d = DONE;
                end
`ifdef MATRIX_CALC_WDOG_EN
                else if (wdog_q == WD_LAST) begin
                    state_d    = ERROR;
                    err_code_d = 2'd3;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
`endif
            end
            DONE: if (btn_rise_q) state_d = MENU;
            ERROR: begin
                if (tick_q == TICK_LAST) begin
                    if (countdown_q != '0) countdown_d = countdown_q - CNT_W'(1);
                    if (countdown_q <= CNT_W'(1)) state_d = MENU;
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Each entry into ERROR reloads the countdown. tick_d already defaults to 0 here.
        if (state_d == ERROR && state_q != ERROR) begin
            start_cd_d  = 1'b1;
            countdown_d = CNT_W'(COUNTDOWN_S);
        end
        error_led_d = (state_d == ERROR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            button_q     <= 1'b0;
            btn_rise_q   <= 1'b0;
            start_calc_q <= 1'b0;
            start_cd_q   <= 1'b0;
            error_led_q  <= 1'b0;
            op_type_q    <= '0;
            err_code_q   <= 2'd0;
            countdown_q  <= '0;
            tick_q       <= '0;
`ifdef MATRIX_CALC_WDOG_EN
            wdog_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            button_q     <= button_d;
            btn_rise_q   <= btn_rise_d;
            start_calc_q <= start_calc_d;
            start_cd_q   <= start_cd_d;
            error_led_q  <= error_led_d;
            op_type_q    <= op_type_d;
            err_code_q   <= err_code_d;
            countdown_q  <= countdown_d;
            tick_q       <= tick_d;
`ifdef MATRIX_CALC_WDOG_EN
            wdog_q       <= wdog_d;
`endif
        end
    end

    assign bus.state           = state_q;
    assign bus.start_calc      = start_calc_q;
    assign bus.op_type         = op_type_q;
    assign bus.error_led       = error_led_q;
    assign bus.err_code        = err_code_q;
    assign bus.start_countdown = start_cd_q;
    assign bus.countdown_val   = countdown_q;
endmodule

// File: tb/tb_matrix_op_sequencer.sv
// Randomised bench for matrix_op_sequencer. Expected op_type and err_code come from a transaction-level scoreboard.
// Expected countdown values are computed arithmetically from the elapsed ERROR cycles.
module tb_matrix_op_sequencer;
    localparam int CLK_FREQ     = 10;
    localparam int OP_W         = 4;
    localparam int NUM_OPS      = 5;
    localparam int COUNTDOWN_S  = 3;
    localparam int CALC_TIMEOUT = 50;
    localparam int CNT_W        = $clog2(COUNTDOWN_S + 1);
    localparam int ERR_CYCLES   = COUNTDOWN_S * CLK_FREQ;

    localparam int S_IDLE = 0, S_MENU = 1, S_CALC = 2, S_DONE = 3, S_ERROR = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    int   exp_op  = 0;
    int   exp_err = 0;

    matrix_op_sequencer_if #(.OP_W(OP_W), .CNT_W(CNT_W)) bus ();

    matrix_op_sequencer #(
        .CLK_FREQ(CLK_FREQ), .OP_W(OP_W), .NUM_OPS(NUM_OPS),
        .COUNTDOWN_S(COUNTDOWN_S), .CALC_TIMEOUT(CALC_TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One full clock: returns on the falling edge after the next rising edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Button high for one cycle. The FSM reacts on the second rising edge.
    task automatic press();
        bus.button = 1'b1;
        step();
        bus.button = 1'b0;
        step();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_state"}, int'(bus.state), 0);
        check({tag, "_start_calc"}, int'(bus.start_calc), 0);
        check({tag, "_op_type"}, int'(bus.op_type), 0);
        check({tag, "_error_led"}, int'(bus.error_led), 0);
        check({tag, "_err_code"}, int'(bus.err_code), 0);
        check({tag, "_start_cd"}, int'(bus.start_countdown), 0);
        check({tag, "_cd_val"}, int'(bus.countdown_val), 0);
    endtask

    // Called at the first ERROR cycle. Follows the whole countdown back to MENU.
    task automatic run_error(input int press_k);
        for (int k = 1; k <= ERR_CYCLES; k++) begin
            check("err_state", int'(bus.state), S_ERROR);
            check("err_led", int'(bus.error_led), 1);
            check("err_code", int'(bus.err_code), exp_err);
            check("err_op_held", int'(bus.op_type), exp_op);
            check("cd_pulse", int'(bus.start_countdown), int'(k == 1));
            check("cd_val", int'(bus.countdown_val), COUNTDOWN_S - (k - 1) / CLK_FREQ);
            bus.button = (k == press_k);
            step();
        end
        bus.button = 1'b0;
        check("rec_state", int'(bus.state), S_MENU);
        check("rec_led", int'(bus.error_led), 0);
        check("rec_cd_val", int'(bus.countdown_val), 0);
        check("rec_err_code", int'(bus.err_code), exp_err);
    endtask

    // Starts and ends in MENU. outcome: 0 done, 1 error_in, 2 both in the same cycle.
    task automatic run_calc(input int mode, input int outcome, input int wait_n, input int btn_k);
        bus.mode_sel = OP_W'(mode);
        press();
        if (mode >= NUM_OPS) begin
            exp_err = 1;
            check("inv_start_calc", int'(bus.start_calc), 0);
            run_error(int'($urandom_range(1, ERR_CYCLES - 5)));
            return;
        end
        exp_op  = mode;
        exp_err = 0;
        check("calc_state", int'(bus.state), S_CALC);
        check("start_calc", int'(bus.start_calc), 1);
        check("op_type", int'(bus.op_type), exp_op);
        check("calc_err_code", int'(bus.err_code), 0);
        for (int c = 0; c < wait_n; c++) begin
            bus.button   = (c == btn_k);
            bus.mode_sel = OP_W'($urandom_range(0, 15));
            step();
            check("calc_wait_state", int'(bus.state), S_CALC);
            check("start_calc_once", int'(bus.start_calc), 0);
        end
        bus.button    = 1'b0;
        bus.calc_done = (outcome != 1);
        bus.error_in  = (outcome != 0);
        step();
        bus.calc_done = 1'b0;
        bus.error_in  = 1'b0;
        if (outcome == 0) begin
            check("done_state", int'(bus.state), S_DONE);
            bus.mode_sel = OP_W'($urandom_range(0, 15));
            step();
            step();
            check("done_state_held", int'(bus.state), S_DONE);
            check("done_op_held", int'(bus.op_type), exp_op);
            press();
            check("done_to_menu", int'(bus.state), S_MENU);
            check("done_err_code", int'(bus.err_code), 0);
        end else begin
            exp_err = 2;
            run_error(int'($urandom_range(1, ERR_CYCLES - 5)));
        end
    endtask

    initial begin
        bus.button    = 1'b0;
        bus.mode_sel  = '0;
        bus.calc_done = 1'b0;
        bus.error_in  = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        step();
        check("post_reset_state", int'(bus.state), S_IDLE);

        bus.button = 1'b1;
        step();
        check("idle_one_cycle", int'(bus.state), S_IDLE);
        bus.button = 1'b0;
        step();
        check("idle_to_menu", int'(bus.state), S_MENU);

        // Directed cases: nominal done, invalid op, done+error collision, and the NUM_OPS boundary.
        run_calc(3, 0, 4, 99);
        run_calc(9, 0, 0, 99);
        run_calc(2, 2, 3, 1);
        run_calc(NUM_OPS - 1, 1, 0, 99);
        run_calc(NUM_OPS, 0, 0, 99);
        run_calc(15, 0, 0, 99);
        run_calc(0, 0, 0, 99);

        for (int i = 0; i < 25; i++) begin
            run_calc(int'($urandom_range(0, 15)), int'($urandom_range(0, 2)),
                     int'($urandom_range(0, 20)), int'($urandom_range(0, 25)));
        end

        // CALC with no completion
        bus.mode_sel = OP_W'(1);
        press();
        exp_op  = 1;
        exp_err = 0;
        check("wd_calc_state", int'(bus.state), S_CALC);
`ifdef MATRIX_CALC_WDOG_EN
        for (int c = 1; c < CALC_TIMEOUT; c++) begin
            step();
            check("wd_still_calc", int'(bus.state), S_CALC);
        end
        step();
        exp_err = 3;
        check("wd_timeout_state", int'(bus.state), S_ERROR);
        run_error(5);

        bus.mode_sel = OP_W'(2);
        press();
        exp_op  = 2;
        exp_err = 0;
        for (int c = 1; c < CALC_TIMEOUT; c++) step();
        check("wd_edge_state", int'(bus.state), S_CALC);
        bus.calc_done = 1'b1;
        step();
        bus.calc_done = 1'b0;
        check("wd_done_wins", int'(bus.state), S_DONE);
        check("wd_done_err_code", int'(bus.err_code), 0);
        press();
        check("wd_back_menu", int'(bus.state), S_MENU);
`else
        for (int c = 1; c <= 200; c++) begin
            step();
            check("nowd_still_calc", int'(bus.state), S_CALC);
        end
        check("nowd_err_code", int'(bus.err_code), 0);
        bus.calc_done = 1'b1;
        step();
        bus.calc_done = 1'b0;
        check("nowd_done", int'(bus.state), S_DONE);
        press();
        check("nowd_back_menu", int'(bus.state), S_MENU);
`endif

        // Asynchronous reset in the middle of the countdown
        bus.mode_sel = OP_W'(9);
        press();
        repeat (CLK_FREQ + 2) step();
        check("mid_err_state", int'(bus.state), S_ERROR);
        check("mid_err_cd_val", int'(bus.countdown_val), COUNTDOWN_S - 1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        repeat (2) @(negedge clk);
        check_all_zero("reset_hold");
        rst_n = 1'b1;
        step();
        check("rel_state", int'(bus.state), S_IDLE);
        check("rel_start_cd", int'(bus.start_countdown), 0);
        press();
        check("rel_to_menu", int'(bus.state), S_MENU);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
